// File: rtl/draw_pkg.sv
// Shared definitions for the draw sequencer and background_datapath.
package draw_pkg;

    localparam int unsigned FRAME_CYCLES_DEF = 833333;
    localparam int unsigned CNT_W_DEF        = 20;
    localparam int unsigned SCREEN_WIDTH     = 160;
    localparam int unsigned SCREEN_HEIGHT    = 120;

    typedef enum logic [3:0] {
        S_START_CLR,
        S_START_BG,
        S_START_WAIT,
        S_GAME_CLR,
        S_GAME_BG,
        S_OBJECTS,
        S_FRAME_WAIT,
        S_UPDATE,
        S_OVER_CLR,
        S_OVER_BG,
        S_OVER_WAIT
    } state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-rate counter: terminal-count tick, pending-frame flag and sticky overrun flag.
module frame_tick_gen #(
    parameter int unsigned FRAME_CYCLES = 833333,
    parameter int unsigned CNT_W        = 20
) (
    input  logic i_clock,
    input  logic i_resetn,
    input  logic i_freeze,
    input  logic i_clear,
    output logic o_frame_pending,
    output logic o_frame_overrun
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_overrun;
    logic             w_tick;

    assign w_tick = (r_cnt == LAST) & ~i_freeze;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (!i_freeze) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
            // A new tick outranks the clear so a frame landing on the exit edge is kept.
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end
            if (w_tick && r_pending && !i_clear) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_frame_pending = r_pending;
    assign o_frame_overrun = r_overrun;

endmodule

// File: rtl/game_draw_control.sv
// Start screen -> per-frame game loop -> game-over screen sequencer.
// Optional pause input in the frame-wait state when GAME_PAUSE_EN is defined.
module game_draw_control
    import draw_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic i_clock,
    input  logic i_resetn,
    input  logic i_start_key,
    input  logic i_lives_zero,
    input  logic i_background_drawn,
    input  logic i_objects_drawn,
`ifdef GAME_PAUSE_EN
    input  logic i_pause,
`endif
    output logic o_draw_start_background,
    output logic o_draw_background,
    output logic o_draw_gameover_background,
    output logic o_gameover,
    output logic o_draw_objects,
    output logic o_update_objects,
    output logic o_plot,
    output logic o_frame_overrun
);

    state_t r_state;
    state_t w_state_next;
    logic   r_start_key_d;
    logic   w_press;
    logic   w_freeze;
    logic   w_clear;
    logic   w_frame_pending;
    logic   w_start_bg, w_game_bg, w_over_bg, w_clr, w_objects, w_update;

    assign w_press = i_start_key & ~r_start_key_d;

`ifdef GAME_PAUSE_EN
    assign w_freeze = i_pause & (r_state == S_FRAME_WAIT);
`else
    assign w_freeze = 1'b0;
`endif

    assign w_clear = (r_state == S_START_WAIT) |
                     ((r_state == S_FRAME_WAIT) & w_frame_pending & ~w_freeze);

    frame_tick_gen #(
        .FRAME_CYCLES (FRAME_CYCLES),
        .CNT_W        (CNT_W)
    ) u_frame_tick_gen (
        .i_clock         (i_clock),
        .i_resetn        (i_resetn),
        .i_freeze        (w_freeze),
        .i_clear         (w_clear),
        .o_frame_pending (w_frame_pending),
        .o_frame_overrun (o_frame_overrun)
    );

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state       <= S_START_CLR;
            r_start_key_d <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_start_key_d <= i_start_key;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_START_CLR:  w_state_next = S_START_BG;
            S_START_BG:   if (i_background_drawn) w_state_next = S_START_WAIT;
            S_START_WAIT: if (w_press) w_state_next = S_GAME_CLR;
            S_GAME_CLR:   w_state_next = S_GAME_BG;
            S_GAME_BG:    if (i_background_drawn) w_state_next = S_OBJECTS;
            S_OBJECTS:    if (i_objects_drawn) w_state_next = S_FRAME_WAIT;
            S_FRAME_WAIT: if (w_frame_pending && !w_freeze) w_state_next = S_UPDATE;
            S_UPDATE:     w_state_next = i_lives_zero ? S_OVER_CLR : S_GAME_CLR;
            S_OVER_CLR:   w_state_next = S_OVER_BG;
            S_OVER_BG:    if (i_background_drawn) w_state_next = S_OVER_WAIT;
            S_OVER_WAIT:  if (w_press) w_state_next = S_START_CLR;
            default:      w_state_next = S_START_CLR;
        endcase
    end

    always_comb begin
        w_start_bg = 1'b0;
        w_game_bg  = 1'b0;
        w_over_bg  = 1'b0;
        w_clr      = 1'b0;
        w_objects  = 1'b0;
        w_update   = 1'b0;
        case (r_state)
            S_START_CLR, S_GAME_CLR, S_OVER_CLR: w_clr = 1'b1;
            S_START_BG: w_start_bg = 1'b1;
            S_GAME_BG:  w_game_bg  = 1'b1;
            S_OVER_BG:  w_over_bg  = 1'b1;
            S_OBJECTS:  w_objects  = 1'b1;
            S_UPDATE:   w_update   = 1'b1;
            default:    ;
        endcase
    end

    // Gating with the reset pin drops every request the moment reset asserts.
    assign o_draw_start_background    = w_start_bg & i_resetn;
    assign o_draw_background          = w_game_bg  & i_resetn;
    assign o_draw_gameover_background = w_over_bg  & i_resetn;
    assign o_gameover                 = w_clr      & i_resetn;
    assign o_draw_objects             = w_objects  & i_resetn;
    assign o_update_objects           = w_update   & i_resetn;
    assign o_plot = o_draw_start_background | o_draw_background |
                    o_draw_gameover_background | o_draw_objects;

endmodule
